// File: rtl/serial_cmp_encoder_if.sv
// Operand, code-stream and result handshakes of the serial compare encoder.
// master: operand source / code and result consumer; slave: the encoder.
interface serial_cmp_encoder_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             code_valid;
    logic             code_ready;
    logic             code_y;
    logic             code_z;
    logic [IDX_W-1:0] bit_idx;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_code;

    modport master (
        output start_valid, a_in, b_in, code_ready, res_ready,
        input  start_ready, code_valid, code_y, code_z, bit_idx, res_valid, res_code
    );

    modport slave (
        input  start_valid, a_in, b_in, code_ready, res_ready,
        output start_ready, code_valid, code_y, code_z, bit_idx, res_valid, res_code
    );
endinterface

// File: rtl/serial_cmp_encoder.sv
// Bit-serial magnitude-compare code generator: scans A/B MSB-first, emits one
// {y,z} code per accepted transfer, stops at the first differing bit and
// presents the final {y,z} result. Codes: 01 equal, 10 A>B, 11 B>A, 00 none.
module serial_cmp_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_cmp_encoder_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             startReady;
    logic             codeValid;
    logic [1:0]       codeYz;
    logic [IDX_W-1:0] bitIdx;
    logic             resValid;
    logic [1:0]       resCode;
    logic [IDX_W-1:0] nextIdx;

    // {y,z} for one bit pair: y flags a difference, z clears only when A>B.
    function automatic logic [1:0] cmpBits(input logic a, input logic b);
        return {a ^ b, ~a | b};
    endfunction

    // Index of the bit presented after the current code is accepted.
    always_comb begin
        nextIdx = bitIdx - IDX_W'(1);
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            opA        <= '0;
            opB        <= '0;
            startReady <= 1'b0;
            codeValid  <= 1'b0;
            codeYz     <= 2'b00;
            bitIdx     <= '0;
            resValid   <= 1'b0;
            resCode    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    startReady <= 1'b1;
                    if (bus.start_valid && startReady) begin
                        opA        <= bus.a_in;
                        opB        <= bus.b_in;
                        startReady <= 1'b0;
                        codeValid  <= 1'b1;
                        bitIdx     <= IDX_W'(WIDTH - 1);
                        codeYz     <= cmpBits(bus.a_in[WIDTH-1], bus.b_in[WIDTH-1]);
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (codeValid && bus.code_ready) begin
                        if (codeYz != 2'b01 || bitIdx == '0) begin
                            // Decided (difference found or last bit equal).
                            resCode   <= codeYz;
                            resValid  <= 1'b1;
                            codeValid <= 1'b0;
                            codeYz    <= 2'b00;
                            state     <= RESULT;
                        end else begin
                            bitIdx <= nextIdx;
                            codeYz <= cmpBits(opA[nextIdx], opB[nextIdx]);
                        end
                    end
                end
                RESULT: begin
                    if (resValid && bus.res_ready) begin
                        resValid   <= 1'b0;
                        resCode    <= 2'b00;
                        startReady <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    startReady <= 1'b0;
                    codeValid  <= 1'b0;
                    resValid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = startReady;
    assign bus.code_valid  = codeValid;
    assign bus.code_y      = codeYz[1];
    assign bus.code_z      = codeYz[0];
    assign bus.bit_idx     = bitIdx;
    assign bus.res_valid   = resValid;
    assign bus.res_code    = resCode;
endmodule

// File: tb/tb_serial_cmp_encoder.sv
// Scoreboard bench for serial_cmp_encoder: the stimulus process queues the
// expected code stream and result, a negedge monitor pops and compares them.
module tb_serial_cmp_encoder;
    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_cmp_encoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    serial_cmp_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int compared = 0;
    int mismatched = 0;
    int codesSeen = 0;
    logic [5:0] expCodeQ[$];
    logic [1:0] expResQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: compare every code and result transfer against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.code_valid && bus.code_ready) begin
                codesSeen++;
                if (expCodeQ.size() == 0) failNow("unexpected code transfer");
                else check("code {y,z,idx}", {bus.code_y, bus.code_z, bus.bit_idx}, expCodeQ.pop_front());
            end
            if (bus.res_valid && bus.res_ready) begin
                if (expResQ.size() == 0) failNow("unexpected result transfer");
                else check("res_code", bus.res_code, expResQ.pop_front());
            end
        end
    end

    // One transaction. diffIdx/res are the hand-computed first differing bit
    // and final code (diffIdx=0,res=01 for equal words). stallIdx, busyIdx,
    // rstIdx select optional stall / busy pulse / reset at that bit (-1 = off).
    task automatic runTxn(input logic [15:0] a, input logic [15:0] b, input int diffIdx,
                          input logic [1:0] res, input int stallIdx, input int busyIdx,
                          input int rstIdx);
        int lastIdx;
        int n;
        bit done;
        bit stalled;
        bit busyDone;
        lastIdx = (rstIdx >= 0) ? rstIdx + 1 : diffIdx;
        for (int i = WIDTH - 1; i >= lastIdx; i--)
            expCodeQ.push_back({(i == diffIdx) ? res : 2'b01, 4'(i)});
        if (rstIdx < 0) expResQ.push_back(res);

        n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.start_ready) begin
            failNow("timeout waiting start_ready");
            return;
        end
        bus.a_in = a;
        bus.b_in = b;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        check("first code latency", bus.code_valid, 1'b1);
        check("start_ready low in scan", bus.start_ready, 1'b0);

        n = 0;
        done = 0;
        stalled = 0;
        busyDone = 0;
        while (!done && n < 200) begin
            n++;
            if (rstIdx >= 0 && bus.code_valid && bus.bit_idx == 4'(rstIdx)) begin
                bus.code_ready = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                bus.code_ready = 1'b1;
                check("reset code_valid", bus.code_valid, 1'b0);
                check("reset res_valid", bus.res_valid, 1'b0);
                check("reset code yz", {bus.code_y, bus.code_z}, 2'b00);
                check("reset start_ready", bus.start_ready, 1'b0);
                @(posedge clk); #1;
                check("start_ready after reset", bus.start_ready, 1'b1);
                check("codes pending after reset", expCodeQ.size(), 0);
                done = 1;
            end else if (stallIdx >= 0 && !stalled && bus.code_valid && bus.bit_idx == 4'(stallIdx)) begin
                stalled = 1;
                bus.code_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    check("stall hold", {bus.code_valid, bus.code_y, bus.code_z, bus.bit_idx},
                          {1'b1, 2'b01, 4'(stallIdx)});
                end
                bus.code_ready = 1'b1;
            end else if (busyIdx >= 0 && !busyDone && bus.code_valid && bus.bit_idx == 4'(busyIdx)) begin
                busyDone = 1;
                check("start_ready while busy", bus.start_ready, 1'b0);
                bus.a_in = '1;
                bus.b_in = '0;
                bus.start_valid = 1'b1;
                @(posedge clk); #1;
                bus.start_valid = 1'b0;
                bus.a_in = '0;
            end else if (bus.res_valid) begin
                check("code_valid low in result", bus.code_valid, 1'b0);
                bus.res_ready = 1'b1;
                @(posedge clk); #1;
                bus.res_ready = 1'b0;
                check("res_valid after handshake", bus.res_valid, 1'b0);
                check("start_ready after handshake", bus.start_ready, 1'b1);
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) failNow("timeout waiting result");
    endtask

    initial begin
        int c0;
        bus.start_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.code_ready = 1'b1;
        bus.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset start_ready", bus.start_ready, 1'b0);
        check("reset code_valid", bus.code_valid, 1'b0);
        check("reset code yz", {bus.code_y, bus.code_z}, 2'b00);
        check("reset bit_idx", bus.bit_idx, 0);
        check("reset res_valid", bus.res_valid, 1'b0);
        check("reset res_code", bus.res_code, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("start_ready after release", bus.start_ready, 1'b1);

        // Early stop, B greater: differs first at bit 3.
        c0 = codesSeen;
        runTxn(16'hDAB5, 16'hDABF, 3, 2'b11, -1, -1, -1);
        check("early-stop code count", codesSeen - c0, 13);

        // Equal words.
        c0 = codesSeen;
        runTxn(16'h1234, 16'h1234, 0, 2'b01, -1, -1, -1);
        check("equal code count", codesSeen - c0, 16);

        // Immediate A greater at bit 15.
        c0 = codesSeen;
        runTxn(16'h8000, 16'h7FFF, 15, 2'b10, -1, -1, -1);
        check("immediate code count", codesSeen - c0, 1);

        // Backpressure at bit 14, A greater at bit 4.
        runTxn(16'h00F0, 16'h00E0, 4, 2'b10, 14, -1, -1);

        // start_valid during scan is ignored; A greater at bit 8.
        runTxn(16'h0F00, 16'h0E00, 8, 2'b10, -1, 12, -1);

        // Reset at bit 9 aborts, then a fresh transaction: A greater at bit 0.
        runTxn(16'hAAAA, 16'hAAAA, 0, 2'b01, -1, -1, 9);
        runTxn(16'h0001, 16'h0000, 0, 2'b10, -1, -1, -1);

        repeat (2) @(posedge clk);
        check("codes left in queue", expCodeQ.size(), 0);
        check("results left in queue", expResQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
